// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM master.
// Contents: access-size encodings, FSM state encodings, byte-lane write-enable constants,
// and helpers that build store lanes and spot misaligned accesses.
package bram_pkg;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10,
        SizeRsvd = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StWait  = 2'b10,
        StResp  = 2'b11
    } state_e;

    localparam logic [3:0] WebNone   = 4'b0000;
    localparam logic [3:0] WebByte0  = 4'b0001;
    localparam logic [3:0] WebHalfLo = 4'b0011;
    localparam logic [3:0] WebHalfHi = 4'b1100;
    localparam logic [3:0] WebWord   = 4'b1111;

    // Byte-lane enables for a store. The reserved size behaves as a word.
    function automatic logic [3:0] store_web(size_e size, logic [1:0] ofs);
        logic [3:0] web;
        case (size)
            SizeByte: web = WebByte0 << ofs;
            SizeHalf: web = ofs[1] ? WebHalfHi : WebHalfLo;
            default:  web = WebWord;
        endcase
        return web;
    endfunction

    // Store data replicated across lanes so that web alone selects the target bytes.
    function automatic logic [31:0] store_data(size_e size, logic [31:0] wdata);
        logic [31:0] data;
        case (size)
            SizeByte: data = {4{wdata[7:0]}};
            SizeHalf: data = {2{wdata[15:0]}};
            default:  data = wdata;
        endcase
        return data;
    endfunction

    function automatic logic misaligned(size_e size, logic [1:0] ofs);
        logic bad;
        case (size)
            SizeByte: bad = 1'b0;
            SizeHalf: bad = ofs[0];
            SizeWord: bad = (ofs != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/bram_master_if.sv
// Bus bundle for the BRAM master: request channel, response channel and BRAM port.
// master modport: the bram_master view (takes requests, drives the BRAM port).
// slave modport:  the surrounding view (issues requests, models the BRAM).
interface bram_master_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        enb;
    logic [3:0]  web;
    logic [31:0] addrb;
    logic [31:0] dinb;
    logic [31:0] doutb;
    logic        rstb_busy;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output enb, web, addrb, dinb,
        input  doutb, rstb_busy
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  enb, web, addrb, dinb,
        output doutb, rstb_busy
    );

endinterface

// File: rtl/bram_load_align.sv
// Load lane extraction: picks the addressed byte or half out of the BRAM word and
// zero- or sign-extends it to 32 bits. Purely combinational.
// Ports: doutb (raw BRAM word), offset (address bits [1:0]), size, is_unsigned,
//        rdata (aligned, extended result).
module bram_load_align
    import bram_pkg::*;
(
    input  logic [31:0] doutb,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = doutb[7:0];
        case (offset)
            2'b00:   byte_lane = doutb[7:0];
            2'b01:   byte_lane = doutb[15:8];
            2'b10:   byte_lane = doutb[23:16];
            default: byte_lane = doutb[31:24];
        endcase
        // A half ignores offset[0]: unaligned halves round down.
        half_lane = offset[1] ? doutb[31:16] : doutb[15:0];

        case (size)
            SizeByte: rdata = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            SizeHalf: rdata = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default:  rdata = doutb;
        endcase
    end

endmodule

// File: rtl/bram_master.sv
// Single-outstanding load/store master for a BRAM port.
// Ports: clkb (clock), rstb (async active-high reset), bus (bram_master_if.master:
//        request/response handshakes plus the enb/web/addrb/dinb/doutb BRAM port and
//        the rstb_busy back-pressure input).
// READ_LATENCY: cycles from the enb cycle to valid doutb (1 or 2).
// Optional macro BRAM_MASTER_ALIGN_CHECK_EN: misaligned halves/words and the reserved
// size are answered with rsp_err=1 without touching the BRAM. Undefined, low address
// bits are ignored and the reserved size acts as a word.
module bram_master
    import bram_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input logic           clkb,
    input logic           rstb,
    bram_master_if.master bus
);

    state_e      state_q, state_d;
    logic        we_q, uns_q, err_q;
    size_e       size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  cnt_q;
    logic        accept, req_fault, last_wait;
    logic [31:0] load_data;

    assign bus.req_ready = (state_q == StIdle) && !bus.rstb_busy;
    assign accept        = bus.req_valid && bus.req_ready;
    assign last_wait     = (state_q == StWait) && (cnt_q == 2'(READ_LATENCY - 1));

`ifdef BRAM_MASTER_ALIGN_CHECK_EN
    assign req_fault = misaligned(size_e'(bus.req_size), bus.req_addr[1:0]);
`else
    assign req_fault = 1'b0;
`endif

    bram_load_align u_load_align (
        .doutb       (bus.doutb),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rdata       (load_data)
    );

    // State register.
    always_ff @(posedge clkb or posedge rstb) begin
        if (rstb) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = req_fault ? StResp : StIssue;
            StIssue: state_d = we_q ? StResp : StWait;
            StWait:  if (last_wait) state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request capture, read-latency counter and load result.
    always_ff @(posedge clkb or posedge rstb) begin
        if (rstb) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SizeByte;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                err_q   <= req_fault;
                size_q  <= size_e'(bus.req_size);
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rdata_q <= '0;
                cnt_q   <= '0;
            end
            if (state_q == StWait) begin
                cnt_q <= cnt_q + 2'd1;
                if (last_wait) rdata_q <= load_data;
            end
        end
    end

    // Outputs decode from state only, so reset clears them without waiting for clkb.
    always_comb begin
        bus.enb       = 1'b0;
        bus.web       = WebNone;
        bus.addrb     = '0;
        bus.dinb      = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        unique case (state_q)
            StIssue: begin
                bus.enb   = 1'b1;
                bus.addrb = {addr_q[31:2], 2'b00};
                bus.web   = we_q ? store_web(size_q, addr_q[1:0]) : WebNone;
                bus.dinb  = we_q ? store_data(size_q, wdata_q) : '0;
            end
            StResp: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = rdata_q;
                bus.rsp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bram_master.sv
// Self-checking bench for bram_master with a READ_LATENCY=1 BRAM model.
module tb_bram_master;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          enbs;
        logic [3:0]  web;
        logic [31:0] addrb;
        logic [31:0] dinb;
    } vec_t;

    logic clkb = 1'b0;
    logic rstb = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    bram_master_if bus ();

    bram_master #(.READ_LATENCY(1)) dut (
        .clkb (clkb),
        .rstb (rstb),
        .bus  (bus)
    );

    always #5 clkb = ~clkb;

    // BRAM model: one-cycle registered read, byte-enabled write.
    logic [31:0] mem [0:15];
    always @(posedge clkb) begin
        if (rstb) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[4] <= 32'h8899AABB;
            bus.doutb <= '0;
        end else if (bus.enb) begin
            for (int i = 0; i < 4; i++)
                if (bus.web[i]) mem[bus.addrb[5:2]][8*i +: 8] <= bus.dinb[8*i +: 8];
            bus.doutb <= mem[bus.addrb[5:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata, logic err, int lat,
                                int enbs, logic [3:0] web, logic [31:0] addrb,
                                logic [31:0] dinb);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat; v.enbs = enbs; v.web = web;
        v.addrb = addrb; v.dinb = dinb;
        return v;
    endfunction

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    endtask

    // Called just after a negedge with req_valid high; returns #1 after the accept edge.
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin
                @(posedge clkb);
                #1;
                bus.req_valid = 1'b0;
                ok = 1'b1;
                return;
            end
            @(negedge clkb);
        end
        bus.req_valid = 1'b0;
    endtask

    // Returns the cycle index (1 = cycle after the accept edge) where rsp_valid shows.
    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clkb);
            if (bus.rsp_valid) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        bit          ok;
        int          lat, enbs;
        logic [3:0]  web_c;
        logic [31:0] addrb_c, dinb_c, rdata_c;
        logic        err_c;
        lat = 0; enbs = 0; web_c = 'x; addrb_c = 'x; dinb_c = 'x; rdata_c = 'x; err_c = 'x;
        @(negedge clkb);
        bus.rsp_ready = 1'b1;
        drive_req(v.we, v.size, v.uns, v.addr, v.wdata);
        wait_accept(ok);
        check({tag, "_accept"}, 32'(ok), 32'd1);
        if (!ok) return;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clkb);
            if (bus.enb) begin
                enbs++;
                web_c = bus.web; addrb_c = bus.addrb; dinb_c = bus.dinb;
            end
            if (bus.rsp_valid) begin
                lat = k; rdata_c = bus.rsp_rdata; err_c = bus.rsp_err;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(v.lat));
        check({tag, "_rdata"}, rdata_c, v.rdata);
        check({tag, "_err"}, 32'(err_c), 32'(v.err));
        check({tag, "_enbs"}, 32'(enbs), 32'(v.enbs));
        if (v.enbs == 1) begin
            check({tag, "_web"}, 32'(web_c), 32'(v.web));
            check({tag, "_addrb"}, addrb_c, v.addrb);
            if (v.we) check({tag, "_dinb"}, dinb_c, v.dinb);
        end
        @(posedge clkb);
        #1;
        check({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [12];
        bit   ok;
        int   lat;

        // Expected values assume the sequential memory effects of earlier vectors.
        vecs[0]  = mk(0, 2'b00, 0, 32'h13, 0, 32'hFFFFFF88, 0, 3, 1, 4'b0000, 32'h10, 0);
        vecs[1]  = mk(0, 2'b01, 1, 32'h12, 0, 32'h00008899, 0, 3, 1, 4'b0000, 32'h10, 0);
        vecs[2]  = mk(0, 2'b01, 0, 32'h10, 0, 32'hFFFFAABB, 0, 3, 1, 4'b0000, 32'h10, 0);
        vecs[3]  = mk(1, 2'b00, 0, 32'h11, 32'hABCDEF5A, 0, 0, 2, 1, 4'b0010, 32'h10,
                      32'h5A5A5A5A);
        vecs[4]  = mk(0, 2'b10, 0, 32'h10, 0, 32'h88995ABB, 0, 3, 1, 4'b0000, 32'h10, 0);
        vecs[5]  = mk(0, 2'b00, 1, 32'h10, 0, 32'h000000BB, 0, 3, 1, 4'b0000, 32'h10, 0);
        vecs[6]  = mk(1, 2'b01, 0, 32'h16, 32'hFFFF1234, 0, 0, 2, 1, 4'b1100, 32'h14,
                      32'h12341234);
        vecs[7]  = mk(1, 2'b10, 0, 32'h18, 32'hCAFEF00D, 0, 0, 2, 1, 4'b1111, 32'h18,
                      32'hCAFEF00D);
        vecs[8]  = mk(0, 2'b10, 0, 32'h18, 0, 32'hCAFEF00D, 0, 3, 1, 4'b0000, 32'h18, 0);
        vecs[9]  = mk(0, 2'b01, 0, 32'h16, 0, 32'h00001234, 0, 3, 1, 4'b0000, 32'h14, 0);
        vecs[10] = mk(0, 2'b00, 0, 32'h19, 0, 32'hFFFFFFF0, 0, 3, 1, 4'b0000, 32'h18, 0);
`ifdef BRAM_MASTER_ALIGN_CHECK_EN
        vecs[11] = mk(0, 2'b10, 0, 32'h12, 0, 32'h00000000, 1, 1, 0, 4'b0000, 32'h10, 0);
`else
        vecs[11] = mk(0, 2'b10, 0, 32'h12, 0, 32'h88995ABB, 0, 3, 1, 4'b0000, 32'h10, 0);
`endif

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b1; bus.rstb_busy = 1'b0;

        // Reset state.
        repeat (3) @(negedge clkb);
        check("rst_enb", 32'(bus.enb), 32'd0);
        check("rst_web", 32'(bus.web), 32'd0);
        check("rst_addrb", bus.addrb, 32'd0);
        check("rst_dinb", bus.dinb, 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        rstb = 1'b0;

        for (int i = 0; i < 12; i++) do_txn(vecs[i], $sformatf("v%0d", i));

        // Response back-pressure: everything holds while rsp_ready is low.
        @(negedge clkb);
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        wait_accept(ok);
        check("bp_accept", 32'(ok), 32'd1);
        wait_rsp(lat);
        check("bp_lat", 32'(lat), 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clkb);
            check($sformatf("bp_valid%0d", i), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("bp_rdata%0d", i), bus.rsp_rdata, 32'hFFFFFF88);
            check($sformatf("bp_req_ready%0d", i), 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clkb);
        #1;
        check("bp_release", 32'(bus.rsp_valid), 32'd0);

        // BRAM busy blocks acceptance.
        @(negedge clkb);
        bus.rstb_busy = 1'b1;
        drive_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clkb);
            check($sformatf("busy_req_ready%0d", i), 32'(bus.req_ready), 32'd0);
            check($sformatf("busy_enb%0d", i), 32'(bus.enb), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rstb_busy = 1'b0;
        do_txn(vecs[4], "after_busy");

        // Reset pulsed while waiting on BRAM read data.
        @(negedge clkb);
        drive_req(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
        wait_accept(ok);
        check("rw_accept", 32'(ok), 32'd1);
        @(negedge clkb);
        check("rw_issue_enb", 32'(bus.enb), 32'd1);
        @(negedge clkb);
        rstb = 1'b1;
        #1;
        check("rw_enb", 32'(bus.enb), 32'd0);
        check("rw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clkb);
        rstb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clkb);
            check($sformatf("rw_no_rsp%0d", i), 32'(bus.rsp_valid), 32'd0);
        end
        // Model memory was reloaded by the reset pulse.
        do_txn(mk(0, 2'b10, 0, 32'h10, 0, 32'h8899AABB, 0, 3, 1, 4'b0000, 32'h10, 0),
               "rw_next");

        // Reset pulsed while a response is held: it must vanish immediately.
        @(negedge clkb);
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        wait_accept(ok);
        check("rr_accept", 32'(ok), 32'd1);
        wait_rsp(lat);
        check("rr_lat", 32'(lat), 32'd3);
        rstb = 1'b1;
        #1;
        check("rr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rr_rsp_rdata", bus.rsp_rdata, 32'd0);
        @(negedge clkb);
        rstb = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clkb);
            check($sformatf("rr_no_rsp%0d", i), 32'(bus.rsp_valid), 32'd0);
        end
        do_txn(mk(1, 2'b10, 0, 32'h20, 32'h01020304, 0, 0, 2, 1, 4'b1111, 32'h20,
                  32'h01020304), "rr_next");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_master.md
BRAM_MASTER -- requirements
Module: bram_master

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1: cycles from the enb cycle to valid doutb; legal values 1..2.
REQ-002 SHALL have port clkb  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port rstb  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  request accepted on a clkb edge where req_valid and req_ready are both high.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  response consumed on a clkb edge where rsp_valid and rsp_ready are both high.
REQ-013 SHALL have port rsp_rdata  output  32  load result; 0 for stores.
REQ-014 SHALL have port rsp_err  output  1  access fault.
REQ-015 SHALL have port enb  output  1  BRAM port enable.
REQ-016 SHALL have port web  output  4  BRAM byte write enables.
REQ-017 SHALL have port addrb  output  32  BRAM byte address, bits [1:0] = 00.
REQ-018 SHALL have port dinb  output  32  BRAM write data.
REQ-019 SHALL have port doutb  input  32  BRAM read data.
REQ-020 SHALL have port rstb_busy  input  1  BRAM busy; no new request is accepted while it is high.

Function
REQ-021 SHALL implement an FSM with states IDLE, ISSUE, WAIT and RESP.
REQ-022 SHALL drive req_ready = (state==IDLE) && !rstb_busy, combinationally.
REQ-023 SHALL, on accept, register the request and move to ISSUE.
REQ-024 SHALL, in ISSUE, hold enb=1 for exactly one cycle with addrb, web and dinb stable, and hold enb=0 in every other state.
REQ-025 SHALL go from ISSUE to WAIT for loads and from ISSUE to RESP for stores.
REQ-026 SHALL, in WAIT, count READ_LATENCY cycles, capture the aligned doutb on the last one, and then enter RESP.
REQ-027 SHALL give an aligned load with READ_LATENCY=1 its rsp_valid 3 cycles after the accept edge, and an aligned store its rsp_valid 2 cycles after the accept edge.
REQ-028 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready is high, then return to IDLE on that edge.
REQ-029 SHALL allow one transaction in flight only, with no overlap with the next accept.
REQ-030 SHALL derive web from req_size and req_addr: byte gives web = 1<<addr[1:0]; half gives 0011 when addr[1]=0 and 1100 when addr[1]=1; word gives 1111; loads give 0000.
REQ-031 SHALL replicate store data on dinb: a byte across all 4 lanes, a half across both halves, a word unchanged.
REQ-032 SHALL select the load lane by addr[1:0] (byte) or addr[1] (half), then zero- or sign-extend it to 32 bits per req_unsigned.
REQ-033 SHALL drive rsp_err=0 for every access when BRAM_MASTER_ALIGN_CHECK_EN is undefined.

Reset
REQ-034 SHALL, while rstb is high, force state to IDLE and drive enb, web, addrb, dinb, rsp_valid, rsp_rdata and rsp_err to 0, immediately and independent of clkb.
REQ-035 SHALL discard an in-flight transaction when rstb is asserted mid-transaction, with no response produced; the first request after rstb deasserts is handled normally.

Configuration
REQ-036 SHALL, with BRAM_MASTER_ALIGN_CHECK_EN defined, treat these as faults: half with addr[0]=1, word with addr[1:0]!=0, and req_size=11.
REQ-037 SHALL, on a fault, never assert enb, go IDLE->RESP, and report rsp_err=1 with rsp_rdata=0 one cycle after accept.
REQ-038 SHALL, with BRAM_MASTER_ALIGN_CHECK_EN undefined, ignore unaligned low address bits (align downward) and treat req_size=11 as word.

Structure
REQ-039 SHALL place the size encodings, FSM state encodings and web lane constants in shared package bram_pkg.
REQ-040 SHALL put load lane extraction and extension in combinational sub-module bram_load_align.

Verification
REQ-041 SHALL cover: word 0x10 preloaded with 0x8899AABB, signed byte load at 0x13 -> rsp_rdata=0xFFFFFF88, rsp_err=0, rsp_valid at accept+3.
REQ-042 SHALL cover: unsigned half load at 0x12 from the same word -> rsp_rdata=0x00008899, and a signed half load at 0x10 -> rsp_rdata=0xFFFFAABB.
REQ-043 SHALL cover: byte store of 0x5A at 0x11 -> web=0010, dinb=0x5A5A5A5A, addrb=0x10, enb high exactly 1 cycle; a following word load at 0x10 -> 0x88995ABB.
REQ-044 SHALL cover: rsp_ready low for 3 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; rstb_busy=1 -> req_ready=0 and no enb.
REQ-045 SHALL cover: word load at 0x12 -> with the macro, rsp_err=1 and enb never high; without it, rsp_rdata = contents of 0x10.
REQ-046 SHALL cover: rstb pulsed during WAIT -> enb=0 and rsp_valid=0 at once, no response emitted, and the next request completes normally.
